dtw_job_ctrl: RTL and testbench

Job sequencer between the AXI-Lite control/status registers and dtw_core.
- Turns CR start/abort/mode/ref_len into a clean core reset, start pulse and latched configuration.
- Tracks core progress by counting source-FIFO reads.
- Checks the sample count against the expected length, then reports busy/done/error, a completion interrupt and the sample count back to the status register.

---
 rtl/dtw_job_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_dtw_job_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_job_ctrl.sv
// ---------------------------------------------------------------------------
// dtw_job_ctrl
// Job sequencer between the AXI-Lite control/status registers and dtw_core.
// Converts CR start/abort/mode/ref_len into a core reset, a start pulse and
// a latched configuration. It also counts source-FIFO reads, checks the count
// against the expected length, and reports status, an irq and the sample count.
//
// Optional build macro: DTW_STALL_CNT_EN
//   When defined, a sink-full stall counter is built. When undefined,
//   stall_cnt is tied to zero.
//
// Ports
//   s00_axi_aclk     clock
//   s00_axi_aresetn  asynchronous active-low reset
//   cr_start         CR start bit (rising edge launches a job)
//   cr_abort         CR abort bit (rising edge aborts a running job)
//   cr_mode          0 = reference load, 1 = query
//   cr_ref_len       reference length in samples
//   sr_clr           one-cycle pulse, clears done/error in IDLE
//   sr               status word {26'b0, err_code, mode, error, done, busy}
//   irq              one-cycle completion pulse
//   core_rst         active-high reset to dtw_core
//   core_start       one-cycle start pulse to dtw_core
//   core_mode        latched mode
//   core_ref_len     latched ref_len
//   core_running     dtw_core running indication
//   src_fifo_rden    core read strobe on the source FIFO (monitored)
//   src_fifo_empty   source FIFO empty (status only)
//   sink_fifo_wren   core write strobe on the sink FIFO (monitored)
//   sink_fifo_full   sink FIFO full
//   sample_cnt       samples consumed in the current or last job
//   stall_cnt        sink-full stall cycles during RUN
// ---------------------------------------------------------------------------
module dtw_job_ctrl #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned SQG_SIZE      = 250,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned START_TIMEOUT = 1024
) (
  input  logic                 s00_axi_aclk,
  input  logic                 s00_axi_aresetn,
  input  logic                 cr_start,
  input  logic                 cr_abort,
  input  logic                 cr_mode,
  input  logic [CNT_WIDTH-1:0] cr_ref_len,
  input  logic                 sr_clr,
  output logic [31:0]          sr,
  output logic                 irq,
  output logic                 core_rst,
  output logic                 core_start,
  output logic                 core_mode,
  output logic [CNT_WIDTH-1:0] core_ref_len,
  input  logic                 core_running,
  input  logic                 src_fifo_rden,
  input  logic                 src_fifo_empty,
  input  logic                 sink_fifo_wren,
  input  logic                 sink_fifo_full,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output logic [31:0]          stall_cnt
);

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned TO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_SHORT   = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_WAIT_RUN,
    S_RUN,
    S_DONE,
    S_ABORT
  } state_e;

  state_e               state_q, state_d;
  logic                 start_lvl_q, abort_lvl_q;
  logic                 start_pls_q, abort_pls_q;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [CNT_WIDTH-1:0] exp_q, exp_d;
  logic                 mode_q, mode_d;
  logic [CNT_WIDTH-1:0] ref_len_q, ref_len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [1:0]           code_q, code_d;
  logic                 irq_q, irq_d;
  logic                 busy_q;
  logic                 core_rst_q;
  logic                 core_start_q;

  logic                 bad_len_c;
  logic                 launch_c;
  logic [CNT_WIDTH-1:0] cnt_inc_c;
  logic [CNT_WIDTH-1:0] run_cnt_c;
  logic                 unused_c;

  // A zero-length reference load is rejected without touching the core
  assign bad_len_c = !cr_mode && (cr_ref_len == '0);
  assign launch_c  = (state_q == S_IDLE) && start_pls_q && !bad_len_c;

  // Saturating sample counter increment
  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign run_cnt_c = src_fifo_rden ? cnt_inc_c : cnt_q;

  // Next-state and next-register logic
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    exp_d     = exp_q;
    mode_d    = mode_q;
    ref_len_d = ref_len_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    error_d   = error_q;
    code_d    = code_q;
    irq_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sr_clr) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = ERR_NONE;
        end
        if (start_pls_q) begin
          if (bad_len_c) begin
            done_d  = 1'b0;
            error_d = 1'b1;
            code_d  = ERR_ABORT;
            irq_d   = 1'b1;
          end else begin
            mode_d    = cr_mode;
            ref_len_d = cr_ref_len;
            exp_d     = cr_mode ? CNT_WIDTH'(SQG_SIZE) : cr_ref_len;
            done_d    = 1'b0;
            error_d   = 1'b0;
            code_d    = ERR_NONE;
            cnt_d     = '0;
            rst_cnt_d = '0;
            state_d   = S_RST;
          end
        end
      end

      S_RST: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          state_d = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_RUN;
      end

      S_WAIT_RUN: begin
        if (core_running) begin
          state_d = S_RUN;
        end else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
          code_d    = ERR_ABORT;
          rst_cnt_d = '0;
          state_d   = S_ABORT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_RUN: begin
        cnt_d = run_cnt_c;
        // A read beyond the expected length means the core overran its job
        if (src_fifo_rden && (cnt_q == exp_q)) begin
          code_d    = ERR_OVERRUN;
          rst_cnt_d = '0;
          state_d   = S_ABORT;
        end else if (!core_running) begin
          if (run_cnt_c != exp_q) begin
            code_d = ERR_SHORT;
          end
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (code_q == ERR_NONE) begin
          done_d = 1'b1;
        end else begin
          error_d = 1'b1;
        end
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end

      S_ABORT: begin
        if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
          error_d = 1'b1;
          if (code_q == ERR_NONE) begin
            code_d = ERR_ABORT;
          end
          irq_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Host abort overrides any in-flight transition; an abort already in
    // progress is not restarted
    if (abort_pls_q && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
      state_d   = S_ABORT;
      rst_cnt_d = '0;
      done_d    = done_q;
      error_d   = error_q;
      irq_d     = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q      <= S_IDLE;
      start_lvl_q  <= 1'b0;
      abort_lvl_q  <= 1'b0;
      start_pls_q  <= 1'b0;
      abort_pls_q  <= 1'b0;
      rst_cnt_q    <= '0;
      to_cnt_q     <= '0;
      exp_q        <= '0;
      mode_q       <= 1'b0;
      ref_len_q    <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      code_q       <= ERR_NONE;
      irq_q        <= 1'b0;
      busy_q       <= 1'b0;
      core_rst_q   <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_lvl_q  <= cr_start;
      abort_lvl_q  <= cr_abort;
      start_pls_q  <= cr_start & ~start_lvl_q;
      abort_pls_q  <= cr_abort & ~abort_lvl_q;
      rst_cnt_q    <= rst_cnt_d;
      to_cnt_q     <= to_cnt_d;
      exp_q        <= exp_d;
      mode_q       <= mode_d;
      ref_len_q    <= ref_len_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      error_q      <= error_d;
      code_q       <= code_d;
      irq_q        <= irq_d;
      busy_q       <= (state_d != S_IDLE);
      core_rst_q   <= (state_d == S_RST) || (state_d == S_ABORT);
      core_start_q <= (state_d == S_START);
    end
  end

  assign sr           = {26'd0, code_q, mode_q, error_q, done_q, busy_q};
  assign irq          = irq_q;
  assign core_rst     = core_rst_q;
  assign core_start   = core_start_q;
  assign core_mode    = mode_q;
  assign core_ref_len = ref_len_q;
  assign sample_cnt   = cnt_q;

`ifdef DTW_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating sink-full stall counter, cleared at launch and held after
  always_comb begin
    stall_d = stall_q;
    if (launch_c) begin
      stall_d = '0;
    end else if ((state_q == S_RUN) && sink_fifo_full && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
  assign unused_c  = ^{src_fifo_empty, sink_fifo_wren};
`else
  assign stall_cnt = '0;
  assign unused_c  = ^{src_fifo_empty, sink_fifo_wren, sink_fifo_full, launch_c};
`endif

endmodule

// File: tb/tb_dtw_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dtw_job_ctrl
// Directed bench for dtw_job_ctrl. Each check compares against a
// hand-computed expected value.
// ---------------------------------------------------------------------------
module tb_dtw_job_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cr_start, cr_abort, cr_mode, sr_clr;
  logic [31:0] cr_ref_len;
  logic [31:0] sr;
  logic        irq, core_rst, core_start, core_mode;
  logic [31:0] core_ref_len;
  logic        core_running, src_fifo_rden, src_fifo_empty;
  logic        sink_fifo_wren, sink_fifo_full;
  logic [31:0] sample_cnt, stall_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int irq_n      = 0;
  int rst_cyc_n  = 0;
  int start_n    = 0;
  int irq_s, rst_s, start_s;

  dtw_job_ctrl dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .cr_start        (cr_start),
    .cr_abort        (cr_abort),
    .cr_mode         (cr_mode),
    .cr_ref_len      (cr_ref_len),
    .sr_clr          (sr_clr),
    .sr              (sr),
    .irq             (irq),
    .core_rst        (core_rst),
    .core_start      (core_start),
    .core_mode       (core_mode),
    .core_ref_len    (core_ref_len),
    .core_running    (core_running),
    .src_fifo_rden   (src_fifo_rden),
    .src_fifo_empty  (src_fifo_empty),
    .sink_fifo_wren  (sink_fifo_wren),
    .sink_fifo_full  (sink_fifo_full),
    .sample_cnt      (sample_cnt),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters for pulse widths and pulse counts
  always @(posedge clk) begin
    if (irq === 1'b1)        irq_n     <= irq_n + 1;
    if (core_rst === 1'b1)   rst_cyc_n <= rst_cyc_n + 1;
    if (core_start === 1'b1) start_n   <= start_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    irq_s   = irq_n;
    rst_s   = rst_cyc_n;
    start_s = start_n;
  endtask

  task automatic wait_core_start(input string tag);
    int n = 0;
    while (core_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_core_start_seen"}, 64'(core_start), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (sr[0] !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_busy_clear"}, 64'(sr[0]), 64'd0);
  endtask

  task automatic rden_pulses(input int count);
    for (int i = 0; i < count; i++) begin
      src_fifo_rden = 1'b1;
      tick();
      src_fifo_rden = 1'b0;
      tick();
    end
  endtask

  task automatic launch(input logic mode, input logic [31:0] len);
    cr_mode    = mode;
    cr_ref_len = len;
    cr_start   = 1'b1;
    tick();
  endtask

  logic [31:0] exp_stall;

  initial begin
    rst_n          = 1'b0;
    cr_start       = 1'b0;
    cr_abort       = 1'b0;
    cr_mode        = 1'b0;
    cr_ref_len     = 32'd0;
    sr_clr         = 1'b0;
    core_running   = 1'b0;
    src_fifo_rden  = 1'b0;
    src_fifo_empty = 1'b0;
    sink_fifo_wren = 1'b0;
    sink_fifo_full = 1'b0;
`ifdef DTW_STALL_CNT_EN
    exp_stall = 32'd37;
`else
    exp_stall = 32'd0;
`endif

    // Reset state
    tick(); tick(); tick();
    check("rst_sr", 64'(sr), 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_core_rst", 64'(core_rst), 64'h0);
    check("rst_core_start", 64'(core_start), 64'h0);
    check("rst_sample_cnt", 64'(sample_cnt), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    rst_n = 1'b1;
    tick(); tick();

    // Abort edge in IDLE is ignored
    snap();
    cr_abort = 1'b1;
    tick(); tick(); tick();
    cr_abort = 1'b0;
    tick();
    check("idle_abort_sr", 64'(sr), 64'h0);
    check("idle_abort_rst", 64'(rst_cyc_n - rst_s), 64'd0);

    // Mode 0 with ref_len 0 is rejected: error code 3, irq, stay IDLE
    snap();
    launch(1'b0, 32'd0);
    tick(); tick(); tick();
    cr_start = 1'b0;
    tick();
    check("badlen_sr", 64'(sr), 64'h34);
    check("badlen_irq", 64'(irq_n - irq_s), 64'd1);
    check("badlen_no_rst", 64'(rst_cyc_n - rst_s), 64'd0);
    sr_clr = 1'b1;
    tick();
    sr_clr = 1'b0;
    tick();
    check("clr_sr", 64'(sr), 64'h0);

    // Job 1: mode 0, ref_len 10, exact length
    snap();
    launch(1'b0, 32'd10);
    wait_core_start("j1");
    cr_start = 1'b0;
    check("j1_rst_cycles", 64'(rst_cyc_n - rst_s), 64'd4);
    check("j1_sr_busy", 64'(sr), 64'h1);
    check("j1_core_ref_len", 64'(core_ref_len), 64'd10);
    check("j1_core_mode", 64'(core_mode), 64'd0);
    core_running = 1'b1;
    tick();
    check("j1_start_one_cycle", 64'(core_start), 64'd0);
    tick(); tick();
    rden_pulses(10);
    core_running = 1'b0;
    wait_idle("j1", 20);
    tick();
    check("j1_sr", 64'(sr), 64'h2);
    check("j1_irq_once", 64'(irq_n - irq_s), 64'd1);
    check("j1_start_once", 64'(start_n - start_s), 64'd1);
    check("j1_sample_cnt", 64'(sample_cnt), 64'd10);
    check("j1_irq_low", 64'(irq), 64'd0);

    // Job 2: mode 1 (expect 250), core stops after 200 reads -> short
    snap();
    launch(1'b1, 32'd0);
    wait_core_start("j2");
    cr_start = 1'b0;
    check("j2_core_mode", 64'(core_mode), 64'd1);
    check("j2_cleared_sr", 64'(sr), 64'h9);
    core_running = 1'b1;
    tick(); tick(); tick();
    rden_pulses(200);
    core_running = 1'b0;
    wait_idle("j2", 20);
    tick();
    check("j2_sr", 64'(sr), 64'h1C);
    check("j2_sample_cnt", 64'(sample_cnt), 64'd200);
    check("j2_irq_once", 64'(irq_n - irq_s), 64'd1);

    // Job 3: mode 0, ref_len 5, sixth read overruns
    launch(1'b0, 32'd5);
    wait_core_start("j3");
    cr_start = 1'b0;
    core_running = 1'b1;
    tick(); tick(); tick();
    rden_pulses(5);
    check("j3_busy_before_overrun", 64'(sr[0]), 64'd1);
    snap();
    rden_pulses(1);
    wait_idle("j3", 20);
    core_running = 1'b0;
    tick();
    check("j3_abort_rst_cycles", 64'(rst_cyc_n - rst_s), 64'd4);
    check("j3_sr", 64'(sr), 64'h24);
    check("j3_irq_once", 64'(irq_n - irq_s), 64'd1);
    check("j3_sample_cnt", 64'(sample_cnt), 64'd6);

    // Job 4: core_running never rises -> start timeout
    launch(1'b0, 32'd3);
    wait_core_start("j4");
    cr_start = 1'b0;
    snap();
    for (int i = 0; i < 1000; i++) tick();
    check("j4_busy_at_1000", 64'(sr[0]), 64'd1);
    wait_idle("j4", 100);
    tick();
    check("j4_rst_cycles", 64'(rst_cyc_n - rst_s), 64'd4);
    check("j4_sr", 64'(sr), 64'h34);
    check("j4_irq_once", 64'(irq_n - irq_s), 64'd1);

    // Job 5: abort mid-RUN, then a start edge while busy is ignored
    launch(1'b0, 32'd20);
    wait_core_start("j5");
    cr_start = 1'b0;
    core_running = 1'b1;
    tick(); tick(); tick();
    rden_pulses(5);
    snap();
    cr_abort = 1'b1;
    tick(); tick();
    cr_start = 1'b1;
    tick();
    wait_idle("j5", 20);
    tick(); tick(); tick();
    check("j5_start_ignored", 64'(start_n - start_s), 64'd0);
    check("j5_still_idle", 64'(sr[0]), 64'd0);
    check("j5_sr", 64'(sr), 64'h34);
    check("j5_sample_cnt", 64'(sample_cnt), 64'd5);
    check("j5_irq_once", 64'(irq_n - irq_s), 64'd1);
    check("j5_abort_rst_cycles", 64'(rst_cyc_n - rst_s), 64'd4);
    cr_start = 1'b0;
    cr_abort = 1'b0;
    core_running = 1'b0;
    tick();

    // Job 6: clean relaunch with counters cleared, sink-full stalls
    launch(1'b0, 32'd2);
    wait_core_start("j6");
    cr_start = 1'b0;
    check("j6_sr_cleared", 64'(sr), 64'h1);
    check("j6_sample_cnt_cleared", 64'(sample_cnt), 64'd0);
    check("j6_core_ref_len", 64'(core_ref_len), 64'd2);
    core_running = 1'b1;
    tick(); tick(); tick();
    sink_fifo_full = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    sink_fifo_full = 1'b0;
    rden_pulses(2);
    core_running = 1'b0;
    wait_idle("j6", 20);
    tick();
    check("j6_sr", 64'(sr), 64'h2);
    check("j6_sample_cnt", 64'(sample_cnt), 64'd2);
    check("j6_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
